// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
//   - MDOp encodings driven from E into md_unit
//   - default busy-cycle counts
//   - MIPS funct codes and the MDUse decode shared by D and E
//   - packed result type {hi, lo} produced by md_arith
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  // True for any instruction that reads or writes HI/LO or uses the unit.
  function automatic logic md_use_decode(input logic [5:0] op, input logic [5:0] funct);
    logic use_md;
    use_md = 1'b0;
    if (op == OP_SPECIAL) begin
      case (funct)
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: use_md = 1'b1;
        default:                            use_md = 1'b0;
      endcase
    end
    return use_md;
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath.
// Ports:
//   i_op  [2:0]  MDOp (MULT/MULTU/DIV/DIVU; others yield zero)
//   i_a   [31:0] rs operand
//   i_b   [31:0] rt operand
//   o_res        {hi, lo} result (remainder/quotient for divides)
//   o_dz         divide by zero on DIV/DIVU
module md_arith
  import md_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output md_res_t     o_res,
  output logic        o_dz
);

  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_b;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [63:0] w_prod;

  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_a_neg  = w_signed & i_a[31];
  assign w_b_neg  = w_signed & i_b[31];

  // Sign-extended 64-bit product; the low 64 bits are exact for both signednesses.
  assign w_prod = {{32{w_a_neg}}, i_a} * {{32{w_b_neg}}, i_b};

  // Divide on magnitudes so 0x80000000 / -1 needs no special case: the
  // quotient magnitude 0x80000000 is left un-negated and reads back correctly.
  assign w_mag_a = w_a_neg ? (~i_a + 32'd1) : i_a;
  assign w_mag_b = w_b_neg ? (~i_b + 32'd1) : i_b;
  assign w_div_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q_mag = w_mag_a / w_div_b;
  assign w_r_mag = w_mag_a % w_div_b;

  assign o_dz = ((i_op == MD_DIV) || (i_op == MD_DIVU)) && (i_b == 32'd0);

  always_comb begin
    o_res = '0;
    case (i_op)
      MD_MULT, MD_MULTU: begin
        o_res.hi = w_prod[63:32];
        o_res.lo = w_prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        o_res.lo = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        o_res.hi = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
      end
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide controller holding architectural HI/LO.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   Start, MDOp       launch pulse and operation from E
//   A, B              forwarded rs/rt operands
//   MDUse_D           D-stage instruction touches HI/LO or the unit
//   Busy, Stall       operation in flight / freeze F-D, bubble E
//   HI, LO            architectural registers
//
// state  | meaning
// S_IDLE | no operation in flight; accepts Start
// S_RUN  | counting down; commits pending result when the count leaves 1
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDUse_D,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  md_res_t          r_pend;
  logic             r_pend_dz;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  md_res_t w_res;
  logic    w_dz;

  md_arith u_arith (
    .i_op  (MDOp),
    .i_a   (A),
    .i_b   (B),
    .o_res (w_res),
    .o_dz  (w_dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_dz <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            case (MDOp)
              MD_MULT, MD_MULTU: begin
                r_state   <= S_RUN;
                r_cnt     <= CNT_W'(MULT_CYCLES);
                r_pend    <= w_res;
                r_pend_dz <= 1'b0;
              end
              MD_DIV, MD_DIVU: begin
                r_state   <= S_RUN;
                r_cnt     <= CNT_W'(DIV_CYCLES);
                r_pend    <= w_res;
                r_pend_dz <= w_dz;
              end
              MD_MTHI: r_hi <= A;
              MD_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
          // Leaving on count 1 makes Busy last exactly the loaded count.
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= S_IDLE;
            if (!r_pend_dz) begin
              r_hi <= r_pend.hi;
              r_lo <= r_pend.lo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy  = (r_state == S_RUN);
  // A launching Start counts: that E instruction has not reached the unit yet.
  assign Stall = MDUse_D && (Start || Busy);
  assign HI    = r_hi;
  assign LO    = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit with a result scoreboard.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        MDUse_D;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MDOp    (MDOp),
    .A       (A),
    .B       (B),
    .MDUse_D (MDUse_D),
    .Busy    (Busy),
    .Stall   (Stall),
    .HI      (HI),
    .LO      (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where Busy has fallen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic inject,
                        input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
    exp_t e;
    int   cnt;
    Start = 1'b1; MDOp = op; A = a; B = b; MDUse_D = use_d;
    sb.push_back('{hi: ehi, lo: elo, cyc: ecyc});
    #1 check("stall_on_start", 64'(Stall), 64'(use_d));
    @(negedge clk);
    Start = 1'b0;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 20) begin
      check("stall_busy", 64'(Stall), 64'(use_d));
      cnt++;
      if (inject && cnt == 2) begin
        Start = 1'b1; MDOp = MD_MTHI; A = 32'h0000_0999;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
    Start = 1'b0;
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      check("busy_cycles", 64'(cnt), 64'(e.cyc));
      check("hi_commit", 64'(HI), 64'(e.hi));
      check("lo_commit", 64'(LO), 64'(e.lo));
      check("stall_after", 64'(Stall), 64'(0));
    end
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    Start = 1'b1; MDOp = op; A = v; MDUse_D = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    if (op == MD_MTHI) check("mthi", 64'(HI), 64'(v));
    else               check("mtlo", 64'(LO), 64'(v));
    check("mt_busy", 64'(Busy), 64'(0));
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = '0; A = '0; B = '0; MDUse_D = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; MDUse_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_hi", 64'(HI), 64'(0));
      check("idle_lo", 64'(LO), 64'(0));
      check("idle_busy", 64'(Busy), 64'(0));
      check("idle_stall", 64'(Stall), 64'(0));
    end

    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA, 5);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h4000_0000, 32'h0, 5);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op(MD_DIVU,  32'd7, 32'd2, 1'b0, 1'b0, 32'd1, 32'd3, 10);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 10);

    mt(MD_MTHI, 32'h0000_0011);
    mt(MD_MTLO, 32'h0000_0022);
    run_op(MD_DIV,  32'd5, 32'd0, 1'b1, 1'b0, 32'h11, 32'h22, 10);
    run_op(MD_DIVU, 32'd9, 32'd0, 1'b0, 1'b0, 32'h11, 32'h22, 10);

    // MTHI arriving while RUN must be dropped and not disturb the count.
    run_op(MD_MULTU, 32'd6, 32'd7, 1'b1, 1'b1, 32'h0, 32'd42, 5);

    mt(MD_MTHI, 32'hDEAD_BEEF);
    mt(MD_MTLO, 32'd5);

    // Reserved opcode in IDLE is ignored.
    Start = 1'b1; MDOp = 3'd6; A = 32'h1234_5678; B = 32'd1;
    @(negedge clk);
    Start = 1'b0;
    check("rsv_busy", 64'(Busy), 64'(0));
    check("rsv_hi", 64'(HI), 64'hDEAD_BEEF);
    check("rsv_lo", 64'(LO), 64'd5);

    // Reset on the third busy cycle of a DIV aborts without commit.
    mt(MD_MTHI, 32'h55);
    mt(MD_MTLO, 32'h55);
    Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    check("pre_rst_busy", 64'(Busy), 64'(1));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_hi", 64'(HI), 64'(0));
    check("rst_lo", 64'(LO), 64'(0));
    repeat (12) @(negedge clk);
    check("rst_nocommit_busy", 64'(Busy), 64'(0));
    check("rst_nocommit_hi", 64'(HI), 64'(0));
    check("rst_nocommit_lo", 64'(LO), 64'(0));

    // Reset wins over a same-cycle Start.
    mt(MD_MTHI, 32'h33);
    reset = 1'b1; Start = 1'b1; MDOp = MD_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk);
    reset = 1'b0; Start = 1'b0;
    check("rst_start_busy", 64'(Busy), 64'(0));
    check("rst_start_hi", 64'(HI), 64'(0));
    repeat (7) @(negedge clk);
    check("rst_start_lo", 64'(LO), 64'(0));
    check("rst_start_idle", 64'(Busy), 64'(0));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
